// File: rtl/mmu_accumulator_pkg.sv
// Shared constants, FSM state type and saturating add for the MMU accumulator stage.
// Lane widths are fixed here so the top and the quantiser agree on them.
package mmu_accumulator_pkg;

    localparam int unsigned LANES = 16;
    localparam int unsigned IN_W  = 20;
    localparam int unsigned ACC_W = 32;
    localparam int unsigned OUT_W = 8;

    typedef enum logic [1:0] {StIdle, StDrain, StLast} acc_state_e;

    localparam logic signed [ACC_W-1:0] AccMax = 32'sh7FFF_FFFF;
    localparam logic signed [ACC_W-1:0] AccMin = 32'sh8000_0000;

    // Quantiser bounds, held at ACC_W+1 bits to compare against the rounded value.
    localparam logic signed [ACC_W:0]   QMaxWide = 33'sd127;
    localparam logic signed [ACC_W:0]   QMinWide = -33'sd128;
    localparam logic signed [OUT_W-1:0] OutMax   = 8'sd127;
    localparam logic signed [OUT_W-1:0] OutMin   = -8'sd128;

    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1]) begin
            return s[ACC_W] ? AccMin : AccMax;
        end
        return s[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/mmu_acc_quant.sv
// Per-lane ReLU, rounding arithmetic right shift and int8 saturation.
// Arithmetic runs at ACC_W+1 bits so the rounding bias never overflows.
module mmu_acc_quant
    import mmu_accumulator_pkg::*;
(
    input  logic signed [ACC_W-1:0] i_val,
    input  logic        [4:0]       i_shift,
    input  logic                    i_relu,
    output logic signed [OUT_W-1:0] o_q
);

    localparam logic signed [ACC_W:0] RoundOne = 33'sd1;

    logic signed [ACC_W:0] w_v;
    logic signed [ACC_W:0] w_bias;
    logic signed [ACC_W:0] w_r;

    always_comb begin
        w_v    = (i_relu && i_val[ACC_W-1]) ? '0 : {i_val[ACC_W-1], i_val};
        w_bias = '0;
        w_r    = w_v;
        if (i_shift != 5'd0) begin
            w_bias = RoundOne <<< (i_shift - 5'd1);
            w_r    = (w_v + w_bias) >>> i_shift;
        end
        if (w_r > QMaxWide) begin
            o_q = OutMax;
        end else if (w_r < QMinWide) begin
            o_q = OutMin;
        end else begin
            o_q = w_r[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/mmu_accumulator.sv
// Accumulator bank behind the MMU: overwrite/accumulate rows in IDLE, then drain a
// wrapping range of rows through the quantiser onto a valid/ready output.
module mmu_accumulator
    import mmu_accumulator_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_data,
    input  logic [AW-1:0]          in_addr,
    input  logic                   in_accumulate,
    input  logic                   drain_start,
    input  logic [AW-1:0]          drain_base,
    input  logic [AW:0]            drain_count,
    input  logic [4:0]             drain_shift,
    input  logic                   relu_en,
    input  logic                   drain_clear,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic                   busy,
    output logic                   drain_done
);

    logic signed [ACC_W-1:0] r_acc [DEPTH][LANES];

    acc_state_e               r_state;
    logic [AW-1:0]            r_ptr;
    logic [AW:0]              r_remain;
    logic [4:0]               r_shift;
    logic                     r_relu;
    logic                     r_clear;
    logic                     r_out_valid;
    logic [LANES*OUT_W-1:0]   r_out_data;
    logic                     r_drain_done;

    logic                     w_wr_en;
    logic                     w_hs;
    logic [AW-1:0]            w_ptr_nxt;
    logic signed [ACC_W-1:0]  w_wr_row [LANES];
    logic signed [ACC_W-1:0]  w_q_src [LANES];
    logic [4:0]               w_q_shift;
    logic                     w_q_relu;
    logic [LANES*OUT_W-1:0]   w_q_row;

    assign w_wr_en   = (r_state == StIdle) && in_valid;
    assign w_hs      = r_out_valid && out_ready;
    assign w_ptr_nxt = r_ptr + AW'(1);

    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            logic signed [ACC_W-1:0] w_lane;
            w_lane = {{(ACC_W-IN_W){in_data[IN_W*j+IN_W-1]}}, in_data[IN_W*j +: IN_W]};
            w_wr_row[j] = in_accumulate ? sat_add(r_acc[in_addr][j], w_lane) : w_lane;
        end
    end

    // In IDLE the first drained row is quantised straight from the inputs, bypassing a
    // same-cycle write; in DRAIN the next row is prepared for the following handshake.
    always_comb begin
        if (r_state == StIdle) begin
            w_q_shift = drain_shift;
            w_q_relu  = relu_en;
            for (int j = 0; j < LANES; j++) begin
                w_q_src[j] = (w_wr_en && (in_addr == drain_base)) ? w_wr_row[j]
                                                                   : r_acc[drain_base][j];
            end
        end else begin
            w_q_shift = r_shift;
            w_q_relu  = r_relu;
            for (int j = 0; j < LANES; j++) begin
                w_q_src[j] = r_acc[w_ptr_nxt][j];
            end
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        mmu_acc_quant u_quant (
            .i_val   (w_q_src[j]),
            .i_shift (w_q_shift),
            .i_relu  (w_q_relu),
            .o_q     (w_q_row[OUT_W*j +: OUT_W])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_ptr        <= '0;
            r_remain     <= '0;
            r_shift      <= '0;
            r_relu       <= 1'b0;
            r_clear      <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_drain_done <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < LANES; j++) begin
                    r_acc[i][j] <= '0;
                end
            end
        end else begin
            r_drain_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_wr_en) begin
                        for (int j = 0; j < LANES; j++) begin
                            r_acc[in_addr][j] <= w_wr_row[j];
                        end
                    end
                    if (drain_start) begin
                        r_ptr    <= drain_base;
                        r_remain <= drain_count;
                        r_shift  <= drain_shift;
                        r_relu   <= relu_en;
                        r_clear  <= drain_clear;
                        if (drain_count == '0) begin
                            r_drain_done <= 1'b1;
                        end else begin
                            r_state     <= StDrain;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_q_row;
                        end
                    end
                end
                StDrain: begin
                    if (w_hs) begin
                        if (r_clear) begin
                            for (int j = 0; j < LANES; j++) begin
                                r_acc[r_ptr][j] <= '0;
                            end
                        end
                        r_ptr    <= w_ptr_nxt;
                        r_remain <= r_remain - (AW+1)'(1);
                        if (r_remain == (AW+1)'(1)) begin
                            r_out_valid  <= 1'b0;
                            r_drain_done <= 1'b1;
                            r_state      <= StLast;
                        end else begin
                            r_out_data <= w_q_row;
                        end
                    end
                end
                StLast: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign in_ready   = (r_state == StIdle);
    assign busy       = (r_state != StIdle);
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign drain_done = r_drain_done;

endmodule

// File: tb/tb_mmu_accumulator.sv
// Directed bench for mmu_accumulator: write/accumulate, quantisation, wrap, stall and reset.
module tb_mmu_accumulator;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [319:0] in_data;
    logic [3:0]   in_addr;
    logic         in_accumulate;
    logic         drain_start;
    logic [3:0]   drain_base;
    logic [4:0]   drain_count;
    logic [4:0]   drain_shift;
    logic         relu_en;
    logic         drain_clear;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
    logic         drain_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mmu_accumulator dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_addr       (in_addr),
        .in_accumulate (in_accumulate),
        .drain_start   (drain_start),
        .drain_base    (drain_base),
        .drain_count   (drain_count),
        .drain_shift   (drain_shift),
        .relu_en       (relu_en),
        .drain_clear   (drain_clear),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .busy          (busy),
        .drain_done    (drain_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [319:0] all_lanes(input logic signed [19:0] v);
        logic [319:0] r;
        for (int j = 0; j < 16; j++) r[20*j +: 20] = v;
        return r;
    endfunction

    task automatic write_row(input logic [3:0] addr, input logic acc, input logic [319:0] d);
        in_valid      = 1'b1;
        in_addr       = addr;
        in_accumulate = acc;
        in_data       = d;
        tick();
        in_valid      = 1'b0;
    endtask

    task automatic start_drain(input logic [3:0] base, input logic [4:0] cnt,
                               input logic [4:0] sh, input logic relu, input logic clr);
        drain_base  = base;
        drain_count = cnt;
        drain_shift = sh;
        relu_en     = relu;
        drain_clear = clr;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
    endtask

    // Waits (bounded) for out_valid, captures the row and takes it with out_ready high.
    task automatic get_row(output logic [127:0] d, output bit ok);
        ok = 1'b0;
        d  = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (out_valid) begin
                d  = out_data;
                ok = 1'b1;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_addr = '0; in_accumulate = 1'b0;
        drain_start = 1'b0; drain_base = '0; drain_count = '0; drain_shift = '0;
        relu_en = 1'b0; drain_clear = 1'b0; out_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_tests++; if (drain_done !== 1'b0) begin n_fail++; $display("FAIL reset_drain_done: got %b want 0", drain_done); end
        n_tests++; if (out_data !== 128'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    endtask

    task automatic test_accumulate();
        logic [127:0] d;
        bit ok;
        write_row(4'd3, 1'b0, all_lanes(20'sd1000));
        write_row(4'd3, 1'b1, all_lanes(-20'sd1500));
        start_drain(4'd3, 5'd1, 5'd0, 1'b0, 1'b0);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL acc_busy: got %b want 1", busy); end
        get_row(d, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL acc_timeout: got no out_valid want a row"); end
        n_tests++; if (d !== {16{8'h80}}) begin n_fail++; $display("FAIL acc_data: got %h want %h", d, {16{8'h80}}); end
        n_tests++; if (drain_done !== 1'b1) begin n_fail++; $display("FAIL acc_done: got %b want 1", drain_done); end
        tick();
        n_tests++; if (drain_done !== 1'b0) begin n_fail++; $display("FAIL acc_done_pulse: got %b want 0", drain_done); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL acc_idle: got %b want 0", busy); end
    endtask

    task automatic test_shift_round();
        logic [319:0] in;
        logic [127:0] exp;
        logic [127:0] d;
        bit ok;
        in = '0;
        in[19:0] = 20'sd300; in[39:20] = 20'sd301; in[59:40] = -20'sd301; in[79:60] = 20'h7FFFF;
        exp = '0;
        exp[7:0] = 8'h4B; exp[15:8] = 8'h4B; exp[23:16] = 8'hB5; exp[31:24] = 8'h7F;
        write_row(4'd5, 1'b0, in);
        start_drain(4'd5, 5'd1, 5'd2, 1'b0, 1'b0);
        get_row(d, ok);
        n_tests++; if (!ok || d !== exp) begin n_fail++; $display("FAIL shift_round: got %h want %h", d, exp); end
        tick();
    endtask

    task automatic test_relu_clear();
        logic [319:0] in;
        logic [127:0] exp;
        logic [127:0] d;
        bit ok;
        in = '0;
        in[19:0] = -20'sd7; in[39:20] = 20'sd9;
        exp = '0;
        exp[15:8] = 8'd9;
        write_row(4'd0, 1'b0, in);
        start_drain(4'd0, 5'd1, 5'd0, 1'b1, 1'b1);
        get_row(d, ok);
        n_tests++; if (!ok || d !== exp) begin n_fail++; $display("FAIL relu: got %h want %h", d, exp); end
        tick();
        start_drain(4'd0, 5'd1, 5'd0, 1'b0, 1'b0);
        get_row(d, ok);
        n_tests++; if (!ok || d !== 128'h0) begin n_fail++; $display("FAIL clear: got %h want 0", d); end
        tick();
    endtask

    task automatic test_wrap_stall();
        logic [127:0] exp;
        write_row(4'd14, 1'b0, all_lanes(20'sd1));
        write_row(4'd15, 1'b0, all_lanes(20'sd2));
        write_row(4'd0,  1'b0, all_lanes(20'sd3));
        write_row(4'd1,  1'b0, all_lanes(20'sd4));
        out_ready = 1'b0;
        start_drain(4'd14, 5'd4, 5'd0, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            exp = {16{8'(r + 1)}};
            out_ready = 1'b0;
            n_tests++; if (out_valid !== 1'b1 || out_data !== exp) begin n_fail++; $display("FAIL wrap_row%0d: got v=%b %h want v=1 %h", r, out_valid, out_data, exp); end
            tick();
            n_tests++; if (out_valid !== 1'b1 || out_data !== exp) begin n_fail++; $display("FAIL wrap_stall%0d: got v=%b %h want v=1 %h", r, out_valid, out_data, exp); end
            n_tests++; if (drain_done !== 1'b0) begin n_fail++; $display("FAIL wrap_early_done%0d: got %b want 0", r, drain_done); end
            out_ready = 1'b1;
            tick();
        end
        n_tests++; if (drain_done !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_done: got done=%b v=%b want done=1 v=0", drain_done, out_valid); end
        tick();
    endtask

    task automatic test_saturation();
        logic [127:0] d;
        bit ok;
        in_valid = 1'b1; in_addr = 4'd2; in_accumulate = 1'b1; in_data = all_lanes(20'h7FFFF);
        repeat (5000) tick();
        in_valid = 1'b0;
        start_drain(4'd2, 5'd1, 5'd24, 1'b0, 1'b0);
        get_row(d, ok);
        n_tests++; if (!ok || d !== {16{8'h7F}}) begin n_fail++; $display("FAIL sat_shift24: got %h want %h", d, {16{8'h7F}}); end
        tick();
        start_drain(4'd2, 5'd1, 5'd31, 1'b0, 1'b0);
        get_row(d, ok);
        n_tests++; if (!ok || d !== {16{8'h01}}) begin n_fail++; $display("FAIL sat_shift31: got %h want %h", d, {16{8'h01}}); end
        tick();
    endtask

    task automatic test_same_cycle();
        logic [127:0] d;
        bit ok;
        in_valid = 1'b1; in_addr = 4'd9; in_accumulate = 1'b0; in_data = all_lanes(20'sd42);
        start_drain(4'd9, 5'd1, 5'd0, 1'b0, 1'b0);
        in_valid = 1'b0;
        get_row(d, ok);
        n_tests++; if (!ok || d !== {16{8'h2A}}) begin n_fail++; $display("FAIL same_cycle: got %h want %h", d, {16{8'h2A}}); end
        tick();
    endtask

    task automatic test_reset_mid_drain();
        logic [127:0] d;
        bit ok;
        write_row(4'd7, 1'b0, all_lanes(20'sd50));
        out_ready = 1'b0;
        start_drain(4'd7, 5'd2, 5'd0, 1'b0, 1'b0);
        n_tests++; if (out_valid !== 1'b1 || out_data !== {16{8'd50}}) begin n_fail++; $display("FAIL mid_pre: got v=%b %h want v=1 %h", out_valid, out_data, {16{8'd50}}); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got v=%b busy=%b want 0 0", out_valid, busy); end
        n_tests++; if (in_ready !== 1'b1 || drain_done !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got rdy=%b done=%b want 1 0", in_ready, drain_done); end
        out_ready = 1'b1;
        start_drain(4'd7, 5'd1, 5'd0, 1'b0, 1'b0);
        get_row(d, ok);
        n_tests++; if (!ok || d !== 128'h0) begin n_fail++; $display("FAIL mid_cleared: got %h want 0", d); end
        tick();
    endtask

    task automatic test_zero_count();
        start_drain(4'd5, 5'd0, 5'd0, 1'b0, 1'b0);
        n_tests++; if (drain_done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b want 1", drain_done); end
        n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_idle: got v=%b busy=%b want 0 0", out_valid, busy); end
        tick();
        n_tests++; if (drain_done !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_pulse: got done=%b v=%b want 0 0", drain_done, out_valid); end
    endtask

    initial begin
        test_reset();
        test_accumulate();
        test_shift_round();
        test_relu_clear();
        test_wrap_stall();
        test_saturation();
        test_same_cycle();
        test_reset_mid_drain();
        test_zero_count();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
